// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants, state encoding and helpers for the
// boot-time instruction-memory loader.
//   - stream/field geometry (header field size, byte lanes, checksum width)
//   - loader state encoding
//   - helper telling which states accept stream bytes
// Optional feature macro used by the loader: IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  // Stream field geometry
  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LANES     = WORD_W / BYTE_W;
  localparam int unsigned CSUM_W    = 32;

  // Byte-lane counter geometry
  localparam int unsigned BCNT_W    = $clog2(HDR_BYTES);
  localparam logic [BCNT_W-1:0] FIRST_LANE = BCNT_W'(0);
  localparam logic [BCNT_W-1:0] LAST_LANE  = BCNT_W'(LANES - 1);

  // Write-pulse counter width (WE_PULSE is 1..4)
  localparam int unsigned PCNT_W    = 3;

  typedef enum logic [3:0] {
    ST_HDR_ADDR = 4'd0,
    ST_HDR_LEN  = 4'd1,
    ST_DATA     = 4'd2,
    ST_WR_SETUP = 4'd3,
    ST_WR_PULSE = 4'd4,
    ST_WR_HOLD  = 4'd5,
    ST_CSUM     = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8
  } state_e;

  // States in which the loader takes bytes from the stream
  function automatic logic state_accepts(input state_e s);
    return (s == ST_HDR_ADDR) || (s == ST_HDR_LEN) ||
           (s == ST_DATA)     || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// imem_loader_asm: little-endian 32-bit field assembler shared by the
// address, length, data and checksum fields.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_clr             restart the byte counter
//   i_byte_en         a stream byte transfers this cycle
//   i_byte            stream byte
//   o_word_c          assembled word, valid together with o_word_valid_c
//   o_word_valid_c    pulses on the transfer of the fourth byte
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_valid_c
);

  logic [BCNT_W-1:0]        r_cnt;
  logic [WORD_W-BYTE_W-1:0] r_shift;

  // Earlier bytes sit low, so the arriving byte completes the top lane
  assign o_word_c       = {i_byte, r_shift};
  assign o_word_valid_c = i_byte_en && (r_cnt == LAST_LANE);

  // Byte counter wraps after the last lane; shift register takes bytes from the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= FIRST_LANE;
      r_shift <= '0;
    end else if (i_clr) begin
      r_cnt   <= FIRST_LANE;
      r_shift <= '0;
    end else if (i_byte_en) begin
      r_cnt   <= r_cnt + BCNT_W'(1);
      r_shift <= {i_byte, r_shift[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the fetch-stage imem debug port.
// Parses {start byte-address, word count, data words[, checksum]} from a
// byte stream (all fields 32-bit little-endian), writes each word into the
// asynchronous SRAM pair with a setup / WE_PULSE-strobe / hold sequence and
// keeps the core in reset until the whole image is written.
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing 32-bit
// checksum (sum mod 2^32 of all data words) before the core is released.
// Parameters:
//   WE_PULSE   cycles debug_imem_we is held low per word (1..4)
//   AW         word-address width of the instruction SRAM
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid, in_data      stream byte offer
//   in_ready               loader takes the byte this cycle
//   core_rst               fetch-stage reset; high while the loader owns imem
//   debug_imem_oe          SRAM output enable (active-low), always 1
//   debug_imem_we          SRAM write enable (active-low)
//   debug_imem_addr/data   word address / write data
//   done                   image loaded, core released
//   err                    protocol error, core stays held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WE_PULSE = 1,
  parameter int unsigned AW       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_rst,
  output logic        debug_imem_oe,
  output logic        debug_imem_we,
  output logic [31:0] debug_imem_addr,
  output logic [31:0] debug_imem_data,
  output logic        done,
  output logic        err
);

  // Number of words the SRAM holds, for the overflow check
  localparam logic [32:0] WORD_SPAN = 33'(1) << AW;

  state_e              r_state;
  logic                r_in_ready;
  logic                r_core_rst;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic                r_done;
  logic                r_err;
  logic [AW-1:0]       r_ptr;
  logic [31:0]         r_remaining;
  logic [PCNT_W-1:0]   r_pulse_cnt;
`ifdef IMEM_LOADER_CSUM_EN
  logic [CSUM_W-1:0]   r_csum;
`endif

  logic                w_byte_en;
  logic                w_clr;
  logic [WORD_W-1:0]   w_word;
  logic                w_word_valid;
  logic [32:0]         w_span_end;

  assign w_byte_en  = in_valid && r_in_ready;
  assign w_clr      = (r_state == ST_DONE) || (r_state == ST_ERR);
  // 33-bit so a huge count cannot wrap past the end of memory
  assign w_span_end = 33'(r_ptr) + 33'(w_word);

  imem_loader_asm u_asm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (w_clr),
    .i_byte_en      (w_byte_en),
    .i_byte         (in_data),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  // Loader FSM; all outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HDR_ADDR;
      r_in_ready  <= 1'b0;
      r_core_rst  <= 1'b1;
      r_we        <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_pulse_cnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        ST_HDR_ADDR: begin
          r_in_ready <= 1'b1;
          if (w_word_valid) begin
            if (w_word[1:0] != 2'b00) begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_ptr   <= w_word[AW+1:2];
              r_state <= ST_HDR_LEN;
            end
          end
        end

        ST_HDR_LEN: begin
          if (w_word_valid) begin
            r_remaining <= w_word;
            if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
              r_state    <= ST_CSUM;
`else
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_core_rst <= 1'b0;
              r_done     <= 1'b1;
`endif
            end else if (w_span_end > WORD_SPAN) begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end

        // Address/data only change here, on the way into WR_SETUP
        ST_DATA: begin
          if (w_word_valid) begin
            r_addr     <= 32'(r_ptr);
            r_data     <= w_word;
            r_in_ready <= 1'b0;
            r_state    <= ST_WR_SETUP;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum     <= r_csum + w_word;
`endif
          end
        end

        ST_WR_SETUP: begin
          r_we        <= 1'b0;
          r_pulse_cnt <= '0;
          r_state     <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (r_pulse_cnt == PCNT_W'(WE_PULSE - 1)) begin
            r_we    <= 1'b1;
            r_state <= ST_WR_HOLD;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
          end
        end

        // we is back high here, so releasing the core on exit is safe
        ST_WR_HOLD: begin
          r_ptr       <= r_ptr + AW'(1);
          r_remaining <= r_remaining - 32'd1;
          if (r_remaining == 32'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
            r_state    <= ST_CSUM;
            r_in_ready <= 1'b1;
`else
            r_state    <= ST_DONE;
            r_core_rst <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= ST_DATA;
            r_in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (w_word_valid) begin
            r_in_ready <= 1'b0;
            if (w_word == r_csum) begin
              r_state    <= ST_DONE;
              r_core_rst <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        ST_DONE: begin
          r_in_ready <= 1'b0;
        end

        ST_ERR: begin
          r_in_ready <= 1'b0;
        end

        // Unreachable encodings park in the error state with the core held
        default: begin
          r_state    <= ST_ERR;
          r_err      <= 1'b1;
          r_in_ready <= 1'b0;
          r_we       <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready && state_accepts(r_state);
  assign core_rst        = r_core_rst;
  // The loader never reads the SRAM
  assign debug_imem_oe   = 1'b1;
  assign debug_imem_we   = r_we;
  assign debug_imem_addr = r_addr;
  assign debug_imem_data = r_data;
  assign done            = r_done;
  assign err             = r_err;

endmodule
